// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// One radix-2 step per cycle; result and rd are registered on entry to DONE.
module ex_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [1:0]  MdOpE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [4:0]  RdE,
  input  logic        FlushE,
  output logic        BusyE,
  output logic        DoneM,
  output logic [31:0] ResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  cnt_q;
  logic [31:0] b_q;
  logic [63:0] prod_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] res_q;
  logic [4:0]  rdm_q;

  logic [32:0] msum;
  logic [63:0] prod_step;
  logic [32:0] dshift;
  logic [32:0] dsub;
  logic        ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] res_step;
  logic        accept;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (StartE && !FlushE) state_d = RUN;
      RUN: begin
        if (FlushE)             state_d = IDLE;
        else if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) && StartE && !FlushE;

  // Shift-add: conditionally add b into the upper half, then shift right.
  assign msum = {1'b0, prod_q[63:32]} +
                (prod_q[0] ? {1'b0, b_q} : 33'd0);
  assign prod_step = {msum, prod_q[31:1]};

  // Restoring division: a borrow in bit 32 means the trial subtract failed.
  assign dshift   = {rem_q, quo_q[31]};
  assign dsub     = dshift - {1'b0, b_q};
  assign ge       = ~dsub[32];
  assign rem_step = ge ? dsub[31:0] : dshift[31:0];
  assign quo_step = {quo_q[30:0], ge};

  always_comb begin
    res_step = prod_step[31:0];
    case (op_q)
      2'b00:   res_step = prod_step[31:0];
      2'b01:   res_step = prod_step[63:32];
      2'b10:   res_step = quo_step;
      2'b11:   res_step = rem_step;
      default: res_step = prod_step[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      rd_q    <= 5'd0;
      cnt_q   <= 5'd0;
      b_q     <= 32'd0;
      prod_q  <= 64'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      res_q   <= 32'd0;
      rdm_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= MdOpE;
        rd_q   <= RdE;
        b_q    <= RD2E;
        prod_q <= {32'd0, RD1E};
        rem_q  <= 32'd0;
        quo_q  <= RD1E;
        cnt_q  <= 5'd0;
      end else if (state_q == RUN && !FlushE) begin
        prod_q <= prod_step;
        rem_q  <= rem_step;
        quo_q  <= quo_step;
        cnt_q  <= cnt_q + 5'd1;
        if (state_d == DONE) begin
          res_q <= res_step;
          rdm_q <= rd_q;
        end
      end
    end
  end

  assign BusyE     = (state_q != IDLE);
  assign DoneM     = (state_q == DONE) && !FlushE;
  assign RegWriteM = DoneM;
  assign ResultM   = res_q;
  assign RdM       = rdm_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, results, stalls,
// flush and reset behaviour with hand-computed expectations.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic [1:0]  MdOpE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [4:0]  RdE;
  logic        FlushE;
  logic        BusyE;
  logic        DoneM;
  logic [31:0] ResultM;
  logic [4:0]  RdM;
  logic        RegWriteM;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic saw_done;

  ex_muldiv dut (
    .clk(clk), .reset(reset), .StartE(StartE), .MdOpE(MdOpE),
    .RD1E(RD1E), .RD2E(RD2E), .RdE(RdE), .FlushE(FlushE),
    .BusyE(BusyE), .DoneM(DoneM), .ResultM(ResultM), .RdM(RdM),
    .RegWriteM(RegWriteM)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (DoneM) saw_done = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; returns in cycle 1 with StartE dropped.
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    MdOpE = op; RD1E = a; RD2E = b; RdE = rd;
    StartE = 1'b1;
    cyc = 0;
    tick(1);
    StartE = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    issue(op, a, b, rd);
    tick(31);
    chk({tag, "_early"}, {31'd0, DoneM}, 32'd0);
    tick(1);
    chk({tag, "_cyc"}, cyc, 33);
    chk({tag, "_done"}, {31'd0, DoneM}, 32'd1);
    chk({tag, "_res"}, ResultM, exp);
    tick(1);
  endtask

  initial begin
    reset = 1'b1; StartE = 1'b0; FlushE = 1'b0;
    MdOpE = 2'd0; RD1E = '0; RD2E = '0; RdE = '0;
    saw_done = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_busy", {31'd0, BusyE}, 32'd0);
    chk("rst_done", {31'd0, DoneM}, 32'd0);
    chk("rst_rw", {31'd0, RegWriteM}, 32'd0);
    chk("rst_res", ResultM, 32'd0);
    chk("rst_rd", {27'd0, RdM}, 32'd0);

    // MUL 7*6 with busy window
    issue(2'b00, 32'd7, 32'd6, 5'd5);
    chk("mul_busy1", {31'd0, BusyE}, 32'd1);
    tick(31);
    chk("mul_nodone32", {31'd0, DoneM}, 32'd0);
    tick(1);
    chk("mul_done33", {31'd0, DoneM}, 32'd1);
    chk("mul_rw33", {31'd0, RegWriteM}, 32'd1);
    chk("mul_busy33", {31'd0, BusyE}, 32'd1);
    chk("mul_res", ResultM, 32'd42);
    chk("mul_rd", {27'd0, RdM}, 32'd5);
    tick(1);
    chk("mul_busy34", {31'd0, BusyE}, 32'd0);
    chk("mul_hold", ResultM, 32'd42);

    run_op("mulhu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,
           32'hFFFFFFFE);
    run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,
           32'h00000001);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd3, 32'd14);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd4, 32'd2);
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 5'd6, 32'hFFFFFFFF);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd7, 32'd5);
    run_op("mulhu_big", 2'b01, 32'h80000000, 32'h00000006, 5'd8,
           32'h00000003);

    // StartE held high: second op only accepted at cycle 34
    issue(2'b00, 32'd2, 32'd3, 5'd1);
    StartE = 1'b1;
    MdOpE = 2'b00; RD1E = 32'd4; RD2E = 32'd5; RdE = 5'd2;
    tick(32);
    chk("held_done33", {31'd0, DoneM}, 32'd1);
    chk("held_res1", ResultM, 32'd6);
    chk("held_rd1", {27'd0, RdM}, 32'd1);
    tick(1);
    chk("held_cyc34_busy", {31'd0, BusyE}, 32'd0);
    tick(1);
    StartE = 1'b0;
    chk("held_busy35", {31'd0, BusyE}, 32'd1);
    chk("held_hold", ResultM, 32'd6);
    tick(31);
    chk("held_nodone66", {31'd0, DoneM}, 32'd0);
    tick(1);
    chk("held_cyc", cyc, 67);
    chk("held_done67", {31'd0, DoneM}, 32'd1);
    chk("held_res2", ResultM, 32'd20);
    chk("held_rd2", {27'd0, RdM}, 32'd2);
    tick(1);

    // Flush at cycle 10 of RUN
    issue(2'b00, 32'd9, 32'd9, 5'd9);
    tick(9);
    FlushE = 1'b1;
    tick(1);
    FlushE = 1'b0;
    chk("flush_busy11", {31'd0, BusyE}, 32'd0);
    saw_done = 1'b0;
    tick(30);
    chk("flush_nodone", {31'd0, saw_done}, 32'd0);
    chk("flush_hold", ResultM, 32'd20);

    // Flush together with start in IDLE
    MdOpE = 2'b00; RD1E = 32'd1; RD2E = 32'd1; RdE = 5'd1;
    StartE = 1'b1; FlushE = 1'b1;
    tick(1);
    StartE = 1'b0; FlushE = 1'b0;
    chk("flushstart_busy", {31'd0, BusyE}, 32'd0);

    // Flush in DONE suppresses the pulse
    issue(2'b00, 32'd10, 32'd10, 5'd10);
    tick(32);
    FlushE = 1'b1;
    #1;
    chk("flushdone_done", {31'd0, DoneM}, 32'd0);
    chk("flushdone_rw", {31'd0, RegWriteM}, 32'd0);
    tick(1);
    FlushE = 1'b0;
    chk("flushdone_busy", {31'd0, BusyE}, 32'd0);

    // Reset at cycle 20 of RUN
    issue(2'b00, 32'd11, 32'd11, 5'd11);
    tick(19);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rrun_busy", {31'd0, BusyE}, 32'd0);
    chk("rrun_done", {31'd0, DoneM}, 32'd0);
    chk("rrun_rw", {31'd0, RegWriteM}, 32'd0);
    chk("rrun_res", ResultM, 32'd0);
    chk("rrun_rd", {27'd0, RdM}, 32'd0);
    saw_done = 1'b0;
    tick(20);
    chk("rrun_nodone", {31'd0, saw_done}, 32'd0);
    run_op("mul_3x3", 2'b00, 32'd3, 32'd3, 5'd12, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=stuck required=finish");
    $fatal(1, "timeout");
  end

endmodule
